// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared types and constants for the full-speed receive path.
// Imported by the DPLL, the receiver top and its interface.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        SE0 = 2'b00,
        J   = 2'b01,
        K   = 2'b10,
        SE1 = 2'b11
    } line_state_t;

    localparam int CLKS_PER_BIT   = 4;
    localparam int BUS_RESET_CLKS = 120;

    // Receive order 0,0,0,0,0,0,0,1 with the oldest bit in the LSB
    localparam logic [7:0] SYNC_PATTERN = 8'h80;

endpackage

// File: rtl/usb_rx_if.sv
// usb_rx_if: receive-side bundle between usb_rx and its consumer.
// master drives the received bytes and line status, slave observes them.
interface usb_rx_if;
    import usb_rx_pkg::*;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_active;
    logic        rx_error;
    line_state_t line_state;
    logic        bus_reset;

    modport master (
        output rx_data, rx_valid, rx_active,
        output rx_error, line_state, bus_reset
    );

    modport slave (
        input rx_data, rx_valid, rx_active,
        input rx_error, line_state, bus_reset
    );

endinterface

// File: rtl/usb_rx_dpll.sv
// usb_rx_dpll: D+/D- synchronizer and bit-phase recovery.
// The phase counter restarts on every line edge; sample fires mid-bit.
module usb_rx_dpll
    import usb_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_dp,
    input  logic        rx_dn,
    output line_state_t line_state,
    output logic        sample
);

    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] phase;

    // Pairs are kept as {dn, dp}, which is the line_state_t encoding
    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= J;
            s2         <= J;
            line_state <= J;
            phase      <= '0;
        end else begin
            s1         <= {rx_dn, rx_dp};
            s2         <= s1;
            line_state <= line_state_t'(s2);
            phase      <= (s2 != line_state) ? 2'd0 : phase + 2'd1;
        end
    end

    assign sample = (phase == 2'(CLKS_PER_BIT / 2));

endmodule

// File: rtl/usb_rx.sv
// usb_rx: full-speed USB receiver.
// NRZI decode, SYNC hunt, de-stuffing, byte assembly, EOP and bus reset.
module usb_rx
    import usb_rx_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     rx_dp,
    input  logic     rx_dn,
    usb_rx_if.master rx
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SYNC  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_EOP   = 3'd3;
    localparam logic [2:0] S_ABORT = 3'd4;

    line_state_t ls;
    line_state_t prev;
    logic        smp;
    logic        jk;
    logic        dec;
    logic [2:0]  state;
    logic [6:0]  sync_h;
    logic [7:0]  shift;
    logic [7:0]  byte_nxt;
    logic [7:0]  data_q;
    logic [7:0]  se0_cnt;
    logic [2:0]  nbits;
    logic [2:0]  ones;
    logic        valid_q;
    logic        err_q;

    usb_rx_dpll u_dpll (
        .clk        (clk),
        .rst        (rst),
        .rx_dp      (rx_dp),
        .rx_dn      (rx_dn),
        .line_state (ls),
        .sample     (smp)
    );

    assign jk       = (ls == J) || (ls == K);
    assign dec      = (ls == prev);
    assign byte_nxt = {dec, shift[7:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            prev    <= J;
            sync_h  <= '0;
            shift   <= '0;
            data_q  <= '0;
            se0_cnt <= '0;
            nbits   <= '0;
            ones    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (ls != SE0)
                se0_cnt <= '0;
            else if (se0_cnt != 8'hFF)
                se0_cnt <= se0_cnt + 8'd1;
            if (smp) begin
                if (jk)
                    prev <= ls;
                unique case (state)
                    S_IDLE: begin
                        // The idle-J to K edge is itself the first SYNC zero
                        if (ls == K) begin
                            state  <= S_SYNC;
                            sync_h <= 7'h3F;
                        end
                    end
                    S_SYNC: begin
                        if (!jk) begin
                            state <= S_IDLE;
                        end else if ({dec, sync_h} == SYNC_PATTERN) begin
                            state <= S_DATA;
                            ones  <= '0;
                            nbits <= '0;
                        end else if (dec) begin
                            state <= S_IDLE;
                        end else begin
                            sync_h <= {dec, sync_h[6:1]};
                        end
                    end
                    S_DATA: begin
                        if (ls == SE0) begin
                            state <= S_EOP;
                            err_q <= (nbits != 3'd0);
                        end else if (ls == SE1) begin
                            state <= S_ABORT;
                            err_q <= 1'b1;
                        end else if (ones == 3'd6) begin
                            if (dec) begin
                                state <= S_ABORT;
                                err_q <= 1'b1;
                            end else begin
                                ones <= '0;
                            end
                        end else begin
                            ones  <= dec ? ones + 3'd1 : 3'd0;
                            shift <= byte_nxt;
                            nbits <= nbits + 3'd1;
                            if (nbits == 3'd7) begin
                                data_q  <= byte_nxt;
                                valid_q <= 1'b1;
                            end
                        end
                    end
                    S_EOP: begin
                        if (ls == J)
                            state <= S_IDLE;
                        else if (ls != SE0)
                            state <= S_ABORT;
                    end
                    S_ABORT: begin
                        if (ls == J)
                            state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign rx.rx_data    = data_q;
    assign rx.rx_valid   = valid_q;
    assign rx.rx_active  = (state == S_DATA) || (state == S_EOP);
    assign rx.rx_error   = err_q;
    assign rx.line_state = ls;
    assign rx.bus_reset  = (se0_cnt >= 8'(BUS_RESET_CLKS));

endmodule

// File: tb/tb_usb_rx.sv
// tb_usb_rx: randomized packet stimulus with a queue scoreboard for usb_rx.
// Expected bytes/errors come from the packet description, not the line decode.
module tb_usb_rx;
    import usb_rx_pkg::*;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dp  = 1'b1;
    logic dn  = 1'b0;

    usb_rx_if rx ();

    usb_rx dut (
        .clk   (clk),
        .rst   (rst),
        .rx_dp (dp),
        .rx_dn (dn),
        .rx    (rx)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    ev_t         expq[$];
    ev_t         got;
    line_state_t sym[$];
    line_state_t nrzi_lvl;
    logic [7:0]  bq[$];
    logic [7:0]  last_data = 8'h00;
    bit          seen_active = 1'b0;
    int          br_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic ev_t mk(input logic e, input logic [7:0] d);
        ev_t v;
        v.err  = e;
        v.data = d;
        return v;
    endfunction

    // Monitor: pops one expectation per DUT strobe
    always @(negedge clk) begin
        if (!rst) begin
            if (rx.rx_active)
                seen_active = 1'b1;
            if (rx.bus_reset)
                br_cnt++;
            if (rx.rx_valid)
                chk("valid_while_active", int'(rx.rx_active), 1);
            if (rx.rx_valid || rx.rx_error) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: valid=%0b error=%0b data=%02h, want none",
                             rx.rx_valid, rx.rx_error, rx.rx_data);
                end else begin
                    got = expq.pop_front();
                    chk("event_is_error", int'(rx.rx_error), int'(got.err));
                    if (!got.err)
                        chk("rx_data", int'(rx.rx_data), int'(got.data));
                end
            end
        end
    end

    task automatic drive(input line_state_t s, input int n);
        {dn, dp} = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add_bit(input bit b);
        if (!b)
            nrzi_lvl = (nrzi_lvl == J) ? K : J;
        sym.push_back(nrzi_lvl);
    endtask

    // Line symbols for SYNC + bytes (+ extra bits) + EOP; byte 'bad' is sent unstuffed
    task automatic build(input int bad, input int extra);
        int ones;
        bit b;
        ones = 0;
        sym.delete();
        nrzi_lvl = J;
        for (int i = 0; i < 7; i++)
            add_bit(1'b0);
        add_bit(1'b1);
        for (int i = 0; i < bq.size(); i++) begin
            for (int k = 0; k < 8; k++) begin
                b = bq[i][k];
                add_bit(b);
                ones = b ? ones + 1 : 0;
                if (ones == 6 && i != bad) begin
                    add_bit(1'b0);
                    ones = 0;
                end
            end
        end
        for (int k = 0; k < extra; k++) begin
            b = 1'($urandom_range(1));
            add_bit(b);
            ones = b ? ones + 1 : 0;
            if (ones == 6) begin
                add_bit(1'b0);
                ones = 0;
            end
        end
        sym.push_back(SE0);
        sym.push_back(SE0);
        sym.push_back(J);
    endtask

    // Bits are 4 clocks; the bit before each edge is stretched or shrunk by one when jit=1
    task automatic play(input bit jit);
        int d;
        for (int i = 0; i < sym.size(); i++) begin
            d = 4;
            if (jit && i + 1 < sym.size() && sym[i + 1] != sym[i])
                d += int'($urandom_range(2)) - 1;
            drive(sym[i], d);
        end
    endtask

    task automatic post();
        drive(J, 24);
        chk("queue_drained", expq.size(), 0);
        expq.delete();
        chk("active_seen", int'(seen_active), 1);
        chk("rx_active_end", int'(rx.rx_active), 0);
        chk("rx_data_hold", int'(rx.rx_data), int'(last_data));
    endtask

    task automatic send(input int bad, input int extra, input bit jit);
        for (int i = 0; i < bq.size(); i++) begin
            if (i == bad) begin
                expq.push_back(mk(1'b1, 8'h00));
                break;
            end
            expq.push_back(mk(1'b0, bq[i]));
            last_data = bq[i];
        end
        if (bad < 0 && (extra % 8) != 0)
            expq.push_back(mk(1'b1, 8'h00));
        build(bad, extra);
        drive(J, 12);
        seen_active = 1'b0;
        play(jit);
        post();
    endtask

    task automatic br_test(input int n);
        drive(J, 16);
        br_cnt = 0;
        drive(SE0, n);
        drive(J, 16);
        chk("bus_reset_cycles", br_cnt, (n >= BUS_RESET_CLKS) ? n - BUS_RESET_CLKS + 1 : 0);
        chk("bus_reset_fell", int'(rx.bus_reset), 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_rx_active", int'(rx.rx_active), 0);
        chk("rst_rx_valid", int'(rx.rx_valid), 0);
        chk("rst_rx_error", int'(rx.rx_error), 0);
        chk("rst_rx_data", int'(rx.rx_data), 0);
        chk("rst_line_state", int'(rx.line_state), int'(J));
        chk("rst_bus_reset", int'(rx.bus_reset), 0);
    endtask

    int len;
    int kind;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;
        drive(J, 20);

        bq.delete(); bq.push_back(8'hE1);
        send(-1, 0, 1'b0);
        bq.delete(); bq.push_back(8'hFF);
        send(-1, 0, 1'b0);
        bq.delete(); bq.push_back(8'hFF);
        send(0, 0, 1'b0);
        bq.delete(); bq.push_back(8'hE1);
        send(-1, 3, 1'b0);

        br_test(130);
        br_test(100);
        br_test(119);
        br_test(120);

        // Reset during the second byte; only the first byte may come out
        bq.delete();
        bq.push_back(8'h55); bq.push_back(8'hAA); bq.push_back(8'h55);
        expq.push_back(mk(1'b0, 8'h55));
        build(-1, 0);
        drive(J, 12);
        seen_active = 1'b0;
        fork
            play(1'b1);
            begin
                repeat (80) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                chk_reset_outputs();
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
        join
        last_data = 8'h00;
        post();

        bq.delete(); bq.push_back(8'hC3); bq.push_back(8'h7E);
        send(-1, 0, 1'b1);

        for (int p = 0; p < 24; p++) begin
            len  = int'($urandom_range(4, 1));
            kind = int'($urandom_range(2));
            bq.delete();
            for (int i = 0; i < len; i++)
                bq.push_back(8'($urandom));
            if (kind == 1) begin
                bq[len - 1] = 8'hFF;
                send(len - 1, 0, 1'b1);
            end else if (kind == 2) begin
                send(-1, int'($urandom_range(7, 1)), 1'b1);
            end else begin
                send(-1, 0, 1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
